// File: rtl/flash_prog_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : flash_prog_sequencer_if
// Brief    : Command/status bundle between the programming sequencer and the
//            UART / QSPI flash macro engines.
// Revision : 1.0
// ============================================================================
interface flash_prog_sequencer_if #(
    parameter int ADDR_W = 32
) ();
    logic [3:0]        macro_states;
    logic              macro_states_valid;
    logic              uart_macro_states_done;
    logic              flash_macro_states_done;
    logic              buff_prog_empty;
    logic              verify_mismatch;
    logic [31:0]       rx_num;
    logic [15:0]       rx_cnt;
    logic [ADDR_W-1:0] addr_reg;

    modport master (
        output macro_states, macro_states_valid, rx_cnt, addr_reg,
        input  uart_macro_states_done, flash_macro_states_done,
               buff_prog_empty, verify_mismatch, rx_num
    );

    modport slave (
        input  macro_states, macro_states_valid, rx_cnt, addr_reg,
        output uart_macro_states_done, flash_macro_states_done,
               buff_prog_empty, verify_mismatch, rx_num
    );
endinterface
`default_nettype wire

// File: rtl/flash_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : flash_prog_sequencer
// Brief    : UART dialogue, sector erase, page program and read-back verify
//            sequencer driving UART/flash macro engines.
// Revision : 1.0
// ============================================================================
module flash_prog_sequencer #(
    parameter int PAGE_BYTES   = 256,
    parameter int SECTOR_BYTES = 4096,
    parameter int ADDR_W       = 32,
    parameter int LEN_W        = 32,
    parameter int MENU_PROG    = 4,
    parameter int VERIFY_EN    = 1,
    parameter int TIMEOUT_CYC  = 2**24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    flash_prog_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             error
);
    localparam int c_SB_LG = $clog2(SECTOR_BYTES);
    localparam int c_PG_LG = $clog2(PAGE_BYTES);
    localparam int c_PPS   = SECTOR_BYTES / PAGE_BYTES;
    localparam int c_CW    = LEN_W + 1;

    typedef enum logic [5:0] {
        ST_IDLE, ST_MENU_S, ST_MENU_W, ST_MSG1_S, ST_MSG1_W, ST_NL1_S, ST_NL1_W,
        ST_ADDR_S, ST_ADDR_W, ST_MSG2_S, ST_MSG2_W, ST_NL2_S, ST_NL2_W,
        ST_LEN_S, ST_LEN_W, ST_MSG3_S, ST_MSG3_W, ST_NL3_S, ST_NL3_W, ST_CALC,
        ST_ERS_S, ST_ERS_W, ST_RDF_S, ST_RDF_W, ST_BUF_S, ST_BUF_W, ST_PG_CHK,
        ST_PG_S, ST_PG_W, ST_VFY_S, ST_VFY_W, ST_DONE, ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic [7:0]        menu_q, menu_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d, addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [c_CW-1:0]   n_sec_q, n_sec_d, n_pg_q, n_pg_d;
    logic [c_CW-1:0]   cnt_q, cnt_d, batch_q, batch_d, cnt_inc, tot;
    logic [15:0]       rx_cnt_q, rx_cnt_d;
    logic              done_q, done_d;
    logic [1:0]        error_q, error_d;
    logic [31:0]       tmr_q, tmr_d;
    logic [3:0]        code;
    logic              is_set, is_wait, ud, fd;

    assign ud = bus.uart_macro_states_done;
    assign fd = bus.flash_macro_states_done;

    always_comb begin
        code = 4'h0;
        case (state_q)
            ST_MENU_S, ST_MENU_W:                                  code = 4'h1;
            ST_ADDR_S, ST_ADDR_W:                                  code = 4'h2;
            ST_LEN_S, ST_LEN_W:                                    code = 4'h3;
            ST_NL1_S, ST_NL1_W, ST_NL2_S, ST_NL2_W, ST_NL3_S, ST_NL3_W: code = 4'h4;
            ST_MSG1_S, ST_MSG1_W, ST_MSG2_S, ST_MSG2_W, ST_MSG3_S, ST_MSG3_W: code = 4'h5;
            ST_RDF_S, ST_RDF_W:                                    code = 4'h6;
            ST_BUF_S, ST_BUF_W:                                    code = 4'h7;
            ST_ERS_S, ST_ERS_W:                                    code = 4'hA;
            ST_PG_S, ST_PG_W:                                      code = 4'hC;
            ST_VFY_S, ST_VFY_W:                                    code = 4'hD;
            default:                                               code = 4'h0;
        endcase
        is_set  = state_q inside {ST_MENU_S, ST_MSG1_S, ST_NL1_S, ST_ADDR_S, ST_MSG2_S,
                                  ST_NL2_S, ST_LEN_S, ST_MSG3_S, ST_NL3_S, ST_ERS_S,
                                  ST_RDF_S, ST_BUF_S, ST_PG_S, ST_VFY_S};
        is_wait = state_q inside {ST_MENU_W, ST_MSG1_W, ST_NL1_W, ST_ADDR_W, ST_MSG2_W,
                                  ST_NL2_W, ST_LEN_W, ST_MSG3_W, ST_NL3_W, ST_ERS_W,
                                  ST_RDF_W, ST_BUF_W, ST_PG_CHK, ST_PG_W, ST_VFY_W};
    end

    always_comb begin
        state_d      = state_q;
        menu_d       = menu_q;
        start_addr_d = start_addr_q;
        len_d        = len_q;
        n_sec_d      = n_sec_q;
        n_pg_d       = n_pg_q;
        cnt_d        = cnt_q;
        batch_d      = batch_q;
        addr_d       = addr_q;
        rx_cnt_d     = rx_cnt_q;
        done_d       = done_q;
        error_d      = error_q;
        cnt_inc      = cnt_q + c_CW'(1);
        // Offset of the image start inside its first sector plus the length
        tot          = c_CW'(start_addr_q[c_SB_LG-1:0]) + c_CW'(len_q);
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_MENU_S;
            ST_MENU_S: state_d = ST_MENU_W;
            ST_MENU_W: if (ud) state_d = ST_MSG1_S;
            ST_MSG1_S: state_d = ST_MSG1_W;
            ST_MSG1_W: if (ud) begin menu_d = bus.rx_num[7:0]; state_d = ST_NL1_S; end
            ST_NL1_S:  state_d = ST_NL1_W;
            ST_NL1_W:  if (ud) state_d = (menu_q == 8'(MENU_PROG)) ? ST_ADDR_S : ST_MENU_S;
            ST_ADDR_S: state_d = ST_ADDR_W;
            ST_ADDR_W: if (ud) state_d = ST_MSG2_S;
            ST_MSG2_S: state_d = ST_MSG2_W;
            ST_MSG2_W: if (ud) begin start_addr_d = bus.rx_num[ADDR_W-1:0]; state_d = ST_NL2_S; end
            ST_NL2_S:  state_d = ST_NL2_W;
            ST_NL2_W:  if (ud) state_d = ST_LEN_S;
            ST_LEN_S:  state_d = ST_LEN_W;
            ST_LEN_W:  if (ud) state_d = ST_MSG3_S;
            ST_MSG3_S: state_d = ST_MSG3_W;
            ST_MSG3_W: if (ud) begin len_d = bus.rx_num[LEN_W-1:0]; state_d = ST_NL3_S; end
            ST_NL3_S:  state_d = ST_NL3_W;
            ST_NL3_W:  if (ud) state_d = ST_CALC;
            ST_CALC: begin
                n_sec_d = (tot + c_CW'(SECTOR_BYTES - 1)) >> c_SB_LG;
                n_pg_d  = (c_CW'(len_q) + c_CW'(PAGE_BYTES - 1)) >> c_PG_LG;
                addr_d  = start_addr_q & ~ADDR_W'(SECTOR_BYTES - 1);
                cnt_d   = '0;
                if (len_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ERS_S;
                end
            end
            ST_ERS_S: state_d = ST_ERS_W;
            ST_ERS_W: if (fd) begin
                addr_d = addr_q + ADDR_W'(SECTOR_BYTES);
                cnt_d  = cnt_inc;
                state_d = ST_ERS_S;
                if (cnt_inc == n_sec_q) begin
                    addr_d  = start_addr_q;
                    cnt_d   = '0;
                    batch_d = '0;
                    state_d = ST_RDF_S;
                end
            end
            ST_RDF_S:  state_d = ST_RDF_W;
            ST_RDF_W:  if (ud) state_d = ST_BUF_S;
            ST_BUF_S:  begin rx_cnt_d = 16'(SECTOR_BYTES); state_d = ST_BUF_W; end
            ST_BUF_W:  if (ud) state_d = ST_PG_CHK;
            ST_PG_CHK: if (!bus.buff_prog_empty) state_d = ST_PG_S;
            ST_PG_S:   state_d = ST_PG_W;
            ST_PG_W: if (fd) begin
                addr_d = addr_q + ADDR_W'(PAGE_BYTES);
                cnt_d  = cnt_inc;
                if (cnt_inc == n_pg_q) begin
                    if (VERIFY_EN != 0) begin
                        addr_d  = start_addr_q;
                        cnt_d   = '0;
                        state_d = ST_VFY_S;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (batch_q == c_CW'(c_PPS - 1)) begin
                    batch_d = '0;
                    state_d = ST_BUF_S;
                end else begin
                    batch_d = batch_q + c_CW'(1);
                    state_d = ST_PG_CHK;
                end
            end
            ST_VFY_S: state_d = ST_VFY_W;
            ST_VFY_W: if (fd) begin
                if (bus.verify_mismatch) begin
                    error_d = 2'd2;
                    state_d = ST_ERR;
                end else begin
                    addr_d  = addr_q + ADDR_W'(PAGE_BYTES);
                    cnt_d   = cnt_inc;
                    state_d = ST_VFY_S;
                    if (cnt_inc == n_pg_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE, ST_ERR: if (start && !start_q) begin
                done_d  = 1'b0;
                error_d = 2'd0;
                state_d = ST_MENU_S;
            end
            default: state_d = ST_IDLE;
        endcase
        // A completion arriving on the expiry cycle still wins over the timeout
        if (TIMEOUT_CYC != 0 && is_wait && state_d == state_q &&
            tmr_q == 32'(TIMEOUT_CYC - 1)) begin
            error_d = 2'd1;
            state_d = ST_ERR;
        end
        tmr_d = (state_d != state_q) ? 32'd0 : tmr_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            menu_q       <= '0;
            start_addr_q <= '0;
            len_q        <= '0;
            n_sec_q      <= '0;
            n_pg_q       <= '0;
            cnt_q        <= '0;
            batch_q      <= '0;
            addr_q       <= '0;
            rx_cnt_q     <= '0;
            done_q       <= 1'b0;
            error_q      <= 2'd0;
            tmr_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            menu_q       <= menu_d;
            start_addr_q <= start_addr_d;
            len_q        <= len_d;
            n_sec_q      <= n_sec_d;
            n_pg_q       <= n_pg_d;
            cnt_q        <= cnt_d;
            batch_q      <= batch_d;
            addr_q       <= addr_d;
            rx_cnt_q     <= rx_cnt_d;
            done_q       <= done_d;
            error_q      <= error_d;
            tmr_q        <= tmr_d;
        end
    end

    assign bus.macro_states       = code;
    assign bus.macro_states_valid = is_set;
    assign bus.addr_reg           = addr_q;
    assign bus.rx_cnt             = rx_cnt_q;
    assign busy                   = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign done                   = done_q;
    assign error                  = error_q;
endmodule
`default_nettype wire

// File: tb/tb_flash_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_prog_sequencer
// Brief    : Directed bench with UART/flash engine responders for the
//            flash programming sequencer.
// Revision : 1.0
// ============================================================================
module tb_flash_prog_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done;
    logic [1:0] error;

    flash_prog_sequencer_if #(.ADDR_W(32)) bus ();

    flash_prog_sequencer #(
        .PAGE_BYTES(256), .SECTOR_BYTES(4096), .ADDR_W(32), .LEN_W(32),
        .MENU_PROG(4), .VERIFY_EN(1), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.master),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        int          n_a, n_c, n_7, n_d;
        logic [31:0] secb;
    } vec_t;

    logic [31:0] answers[$];
    logic [3:0]  log_code[$];
    logic [31:0] log_addr[$];
    logic [15:0] rxcnt_seen = '0;
    int          buf_viol = 0;
    int          d_cnt = 0;
    int          t7 = 0;
    int          mismatch_at = 0;
    bit          hold_flash = 1'b0;
    bit          early = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    int          empty_cnt = 0;
    logic [3:0]  rcode;
    bit          is_fl;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Engine model: logs every strobe and answers after two cycles
    initial begin
        bus.uart_macro_states_done  = 1'b0;
        bus.flash_macro_states_done = 1'b0;
        bus.verify_mismatch         = 1'b0;
        bus.rx_num                  = '0;
        forever begin
            @(posedge clk); #1;
            bus.uart_macro_states_done = 1'b0; bus.flash_macro_states_done = 1'b0;
            bus.verify_mismatch = 1'b0;
            if (bus.macro_states_valid === 1'b1) begin
                rcode = bus.macro_states;
                is_fl = (rcode >= 4'hA);
                log_code.push_back(rcode);
                log_addr.push_back(bus.addr_reg);
                if (rcode == 4'h1) d_cnt = 0;
                if (rcode == 4'h7) begin rxcnt_seen = bus.rx_cnt; t7 = cyc; end
                if (rcode == 4'hC && (cyc - t7) < 9) buf_viol++;
                if (rcode == 4'h5) begin
                    if (answers.size() > 0) bus.rx_num = answers.pop_front();
                    else bus.rx_num = 32'd0;
                end
                if (early) begin
                    if (is_fl) bus.flash_macro_states_done = 1'b1;
                    else       bus.uart_macro_states_done  = 1'b1;
                end
                if (!(is_fl && hold_flash)) begin
                    @(posedge clk); #1;
                    bus.uart_macro_states_done = 1'b0; bus.flash_macro_states_done = 1'b0;
                    if (early) begin
                        if (is_fl) bus.uart_macro_states_done  = 1'b1;
                        else       bus.flash_macro_states_done = 1'b1;
                    end
                    @(posedge clk); #1;
                    bus.uart_macro_states_done = 1'b0; bus.flash_macro_states_done = 1'b0;
                    if (is_fl) begin
                        bus.flash_macro_states_done = 1'b1;
                        if (rcode == 4'hD) begin
                            d_cnt++;
                            bus.verify_mismatch = (d_cnt == mismatch_at);
                        end
                    end else begin
                        bus.uart_macro_states_done = 1'b1;
                    end
                end
            end
        end
    end

    // Receive buffer reads empty for 8 cycles after every fill command
    initial begin
        bus.buff_prog_empty = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.macro_states_valid === 1'b1 && bus.macro_states == 4'h7) empty_cnt = 8;
            else if (empty_cnt > 0) empty_cnt--;
            bus.buff_prog_empty = (empty_cnt > 0);
        end
    end

    task automatic begin_session(output int lb, output int vb);
        repeat (4) @(posedge clk);
        #1;
        lb = log_code.size();
        vb = buf_viol;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("restart_state", {busy, done, error}, {1'b1, 1'b0, 2'd0});
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done === 1'b1 || error !== 2'd0) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20000) begin
            n_checks++; n_err++;
            $display("FAIL session_end: no done/error within %0d cycles", n);
        end
    endtask

    task automatic wait_code(input logic [3:0] c);
        int n;
        n = 0;
        while (!(bus.macro_states_valid === 1'b1 && bus.macro_states == c) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) begin
            n_checks++; n_err++;
            $display("FAIL wait_code: code %0h never strobed", c);
        end
    endtask

    initial begin
        vec_t        vecs[6];
        logic [3:0]  exp1[12];
        int          lb, vb, na, nc, n7, nd, aerr, sz;

        vecs[0] = '{32'h0000_1000, 32'h2000, 2, 32, 2, 32, 32'h0000_1000};
        vecs[1] = '{32'h0000_0F80, 32'h0100, 2, 1, 1, 1, 32'h0000_0000};
        vecs[2] = '{32'h0000_0000, 32'h1001, 2, 17, 2, 17, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FF00, 32'h0200, 2, 2, 1, 2, 32'hFFFF_F000};
        vecs[4] = '{32'h0000_2345, 32'h0000, 0, 0, 0, 0, 32'h0000_2000};
        vecs[5] = '{32'h0000_3000, 32'h1000, 1, 16, 1, 16, 32'h0000_3000};
        exp1 = '{4'h1, 4'h5, 4'h4, 4'h1, 4'h5, 4'h4, 4'h2, 4'h5, 4'h4, 4'h3, 4'h5, 4'h4};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_status", {busy, done, error}, 4'b0);
        chk("reset_bus", {bus.macro_states, bus.macro_states_valid, bus.rx_cnt, bus.addr_reg}, 53'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_status", {busy, done, error, bus.macro_states_valid}, 5'b0);

        // Wrong menu code first, then zero length
        answers.push_back(32'd3); answers.push_back(32'd4);
        answers.push_back(32'h100); answers.push_back(32'd0);
        begin_session(lb, vb);
        wait_end();
        chk("menu_len0_count", log_code.size() - lb, 12);
        aerr = 0;
        for (int k = 0; k < 12; k++)
            if (lb + k < log_code.size() && log_code[lb + k] != exp1[k]) aerr++;
        chk("menu_len0_codes", aerr, 0);
        chk("menu_len0_done", {done, busy, error}, {1'b1, 1'b0, 2'd0});

        for (int i = 0; i < 6; i++) begin
            early = (i % 2 == 1);
            answers.push_back(32'd4); answers.push_back(vecs[i].addr);
            answers.push_back(vecs[i].len);
            begin_session(lb, vb);
            wait_end();
            na = 0; nc = 0; n7 = 0; nd = 0; aerr = 0;
            for (int k = lb; k < log_code.size(); k++) begin
                case (log_code[k])
                    4'hA: begin
                        if (log_addr[k] !== 32'(vecs[i].secb + 32'(na) * 32'd4096)) aerr++;
                        na++;
                    end
                    4'hC: begin
                        if (log_addr[k] !== 32'(vecs[i].addr + 32'(nc) * 32'd256)) aerr++;
                        nc++;
                    end
                    4'hD: begin
                        if (log_addr[k] !== 32'(vecs[i].addr + 32'(nd) * 32'd256)) aerr++;
                        nd++;
                    end
                    4'h7: n7++;
                    default: ;
                endcase
            end
            chk($sformatf("v%0d_erase_cnt", i), na, vecs[i].n_a);
            chk($sformatf("v%0d_prog_cnt", i), nc, vecs[i].n_c);
            chk($sformatf("v%0d_fill_cnt", i), n7, vecs[i].n_7);
            chk($sformatf("v%0d_verify_cnt", i), nd, vecs[i].n_d);
            chk($sformatf("v%0d_addr_seq", i), aerr, 0);
            chk($sformatf("v%0d_buf_wait", i), buf_viol - vb, 0);
            chk($sformatf("v%0d_status", i), {done, busy, error}, {1'b1, 1'b0, 2'd0});
            if (vecs[i].n_7 > 0) chk($sformatf("v%0d_rx_cnt", i), rxcnt_seen, 16'd4096);
        end
        early = 1'b0;

        // Verify mismatch on the third page
        mismatch_at = 3;
        answers.push_back(32'd4); answers.push_back(32'h1000); answers.push_back(32'h800);
        begin_session(lb, vb);
        wait_end();
        sz = log_code.size();
        repeat (20) @(posedge clk);
        #1;
        nd = 0;
        for (int k = lb; k < log_code.size(); k++) if (log_code[k] == 4'hD) nd++;
        chk("mis_error", error, 2'd2);
        chk("mis_addr", bus.addr_reg, 32'h1200);
        chk("mis_verify_cnt", nd, 3);
        chk("mis_no_more", log_code.size() - sz, 0);
        chk("mis_status", {done, busy}, 2'b00);
        mismatch_at = 0;

        // Flash completion withheld after the first erase
        hold_flash = 1'b1;
        answers.push_back(32'd4); answers.push_back(32'h1000); answers.push_back(32'h100);
        begin_session(lb, vb);
        wait_code(4'hA);
        repeat (95) @(posedge clk);
        #1;
        chk("to_before", {error, busy}, {2'd0, 1'b1});
        repeat (10) @(posedge clk);
        #1;
        chk("to_after", {error, busy, done}, {2'd1, 1'b0, 1'b0});
        hold_flash = 1'b0;

        // Asynchronous reset in the middle of programming
        answers.push_back(32'd4); answers.push_back(32'h1000); answers.push_back(32'h2000);
        begin_session(lb, vb);
        wait_code(4'hC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_status", {busy, done, error}, 4'b0);
        chk("arst_bus", {bus.macro_states, bus.macro_states_valid, bus.rx_cnt, bus.addr_reg}, 53'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
